eth_tx_arbiter: RTL

- Shares the single Ethernet MAC transmit datapath between three frame sources: ARP response generator, ARP request generator and UDP transmitter.
- Arbitrates requests, drives the TX source mux select and the frame-start strobe, and waits for frame completion.
- Enforces the inter-frame gap and returns a per-source end pulse.
- Sits between the ARP cache/timer logic and the MAC TX framer (preamble/FCS).

---
 rtl/eth_tx_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares the MAC TX datapath between the ARP response, ARP
// request and UDP frame sources. Grants one source per frame, strobes the
// framer, waits for tx_done (or a watchdog timeout), then holds the
// inter-frame gap before arbitrating again.
module eth_tx_arbiter #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ARP_BURST_MAX  = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       arp_resp_req,
  input  logic       arp_rq_req,
  input  logic       udp_tx_req,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [1:0] tx_sel,
  output logic       arp_resp_grant,
  output logic       arp_rq_grant,
  output logic       udp_tx_grant,
  output logic       arp_resp_end,
  output logic       arp_rq_end,
  output logic       udp_tx_end,
  output logic       tx_abort,
  output logic       busy
);

  localparam int TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam int IFG_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int BURST_W = $clog2(ARP_BURST_MAX + 1);

  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IFG_W-1:0]   IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(ARP_BURST_MAX);

  localparam logic [1:0] SEL_RESP = 2'd0;
  localparam logic [1:0] SEL_RQ   = 2'd1;
  localparam logic [1:0] SEL_UDP  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_IFG  = 2'd2
  } state_t;

  // Grant/end vectors are ordered {udp, arp_rq, arp_resp}
  state_t               state, state_nxt;
  logic [2:0]           grant, grant_nxt;
  logic [2:0]           end_pls, end_nxt;
  logic [1:0]           sel, sel_nxt;
  logic                 start_r, start_nxt;
  logic                 abort_r, abort_nxt;
  logic                 busy_r, busy_nxt;
  logic                 rq_pending, rq_pend_nxt;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt;
  logic [IFG_W-1:0]     ifg_cnt, ifg_nxt;
  logic [TO_W-1:0]      to_cnt, to_nxt;
  logic                 rq_req;
  logic                 rq_grant;
  logic                 pick_udp;

  // A fresh pulse is served in the same arbitration as a latched one
  assign rq_req = rq_pending | arp_rq_req;

  // Next-state, arbitration, counters and registered output values
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    end_nxt   = 3'b000;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    busy_nxt  = busy_r;
    burst_nxt = burst_cnt;
    ifg_nxt   = ifg_cnt;
    to_nxt    = to_cnt;
    rq_grant  = 1'b0;
    pick_udp  = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (arp_resp_req || rq_req || udp_tx_req) begin
          state_nxt = ST_BUSY;
          start_nxt = 1'b1;
          busy_nxt  = 1'b1;
          to_nxt    = '0;
          if (udp_tx_req && (burst_cnt == BURST_MAX)) begin
            pick_udp = 1'b1;
          end else if (arp_resp_req) begin
            grant_nxt = 3'b001;
            sel_nxt   = SEL_RESP;
          end else if (rq_req) begin
            grant_nxt = 3'b010;
            sel_nxt   = SEL_RQ;
            rq_grant  = 1'b1;
          end else begin
            pick_udp = 1'b1;
          end
          if (pick_udp) begin
            grant_nxt = 3'b100;
            sel_nxt   = SEL_UDP;
          end
          // Count ARP wins only while UDP is actually waiting
          if (pick_udp || !udp_tx_req) begin
            burst_nxt = '0;
          end else if (burst_cnt != BURST_MAX) begin
            burst_nxt = burst_cnt + 1'b1;
          end
        end
      end

      ST_BUSY: begin
        // tx_done takes precedence over a coincident timeout
        if (tx_done || (to_cnt == TO_LAST)) begin
          end_nxt   = grant;
          abort_nxt = ~tx_done;
          grant_nxt = 3'b000;
          sel_nxt   = SEL_NONE;
          state_nxt = ST_IFG;
          ifg_nxt   = '0;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end

      ST_IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          ifg_nxt = ifg_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 3'b000;
        sel_nxt   = SEL_NONE;
        busy_nxt  = 1'b0;
      end
    endcase

    rq_pend_nxt = rq_grant ? 1'b0 : (rq_pending | arp_rq_req);
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      grant      <= 3'b000;
      end_pls    <= 3'b000;
      sel        <= SEL_NONE;
      start_r    <= 1'b0;
      abort_r    <= 1'b0;
      busy_r     <= 1'b0;
      rq_pending <= 1'b0;
      burst_cnt  <= '0;
      ifg_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      end_pls    <= end_nxt;
      sel        <= sel_nxt;
      start_r    <= start_nxt;
      abort_r    <= abort_nxt;
      busy_r     <= busy_nxt;
      rq_pending <= rq_pend_nxt;
      burst_cnt  <= burst_nxt;
      ifg_cnt    <= ifg_nxt;
      to_cnt     <= to_nxt;
    end
  end

  assign tx_start       = start_r;
  assign tx_sel         = sel;
  assign arp_resp_grant = grant[0];
  assign arp_rq_grant   = grant[1];
  assign udp_tx_grant   = grant[2];
  assign arp_resp_end   = end_pls[0];
  assign arp_rq_end     = end_pls[1];
  assign udp_tx_end     = end_pls[2];
  assign tx_abort       = abort_r;
  assign busy           = busy_r;

endmodule
